// File: rtl/core_pkg.sv
// Shared sizes and types for the small-queue slot allocator.
package core_pkg;
  localparam int ALLOC_ENTRIES = 8;
  localparam int ALLOC_IDX_W   = 3;

  typedef logic [ALLOC_IDX_W-1:0]   alloc_idx_t;
  typedef logic [ALLOC_ENTRIES-1:0] alloc_vec_t;
endpackage

// File: rtl/and8.sv
// 8-input AND reduction; forms the allocator's full flag from the valid vector.
module and8
  import core_pkg::*;
(
  input  alloc_vec_t a,
  output logic       y
);
  assign y = &a;
endmodule

// File: rtl/prio_enc8.sv
// 8-bit priority encoder: returns the first set bit, scanning from bit 0 when
// LOW_FIRST != 0, otherwise from bit 7. idx is 0 when nothing is found.
module prio_enc8
  import core_pkg::*;
#(
  parameter int LOW_FIRST = 1
) (
  input  alloc_vec_t vec,
  output alloc_idx_t idx,
  output logic       found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < ALLOC_ENTRIES; i++) begin
      if (LOW_FIRST != 0) begin
        if (!found && vec[i]) begin
          idx   = ALLOC_IDX_W'(i);
          found = 1'b1;
        end
      end else begin
        if (!found && vec[ALLOC_ENTRIES-1-i]) begin
          idx   = ALLOC_IDX_W'(ALLOC_ENTRIES-1-i);
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/entry_alloc8.sv
// 8-slot valid-vector allocator: one grant per cycle, dealloc/flush frees.
// Optional ENTRY_ALLOC_STALL_CNT_EN adds a saturating full-stall counter.
module entry_alloc8
  import core_pkg::*;
#(
  parameter int LOW_FIRST = 1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output alloc_idx_t       alloc_idx,
  input  logic             dealloc_vld,
  input  alloc_idx_t       dealloc_idx,
  input  logic             flush,
  output alloc_vec_t       valid_vec,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy,
  output logic             dealloc_err
`ifdef ENTRY_ALLOC_STALL_CNT_EN
  ,output logic [15:0]     stall_cnt
`endif
);
  alloc_vec_t free_vec;
  alloc_idx_t enc_idx;
  logic       enc_found;
  logic       dealloc_hit;
  alloc_vec_t set_mask;
  alloc_vec_t clr_mask;

  // Grants look only at registered state, so a slot freed this cycle waits a cycle.
  assign free_vec = ~valid_vec;

  prio_enc8 #(.LOW_FIRST(LOW_FIRST)) u_enc (
    .vec   (free_vec),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Gating with rst_aL keeps a grant from leaking out while reset is asserted.
  assign alloc_gnt   = alloc_req & enc_found & ~flush & rst_aL;
  assign alloc_idx   = alloc_gnt ? enc_idx : '0;
  assign dealloc_hit = dealloc_vld & valid_vec[dealloc_idx];
  assign set_mask    = alloc_gnt   ? (alloc_vec_t'(1) << alloc_idx)   : '0;
  assign clr_mask    = dealloc_vld ? (alloc_vec_t'(1) << dealloc_idx) : '0;

  and8 u_full (
    .a (valid_vec),
    .y (full)
  );

  assign empty = ~|valid_vec;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      valid_vec   <= '0;
      occupancy   <= '0;
      dealloc_err <= 1'b0;
    end else if (flush) begin
      valid_vec   <= '0;
      occupancy   <= '0;
    end else begin
      valid_vec   <= (valid_vec | set_mask) & ~clr_mask;
      occupancy   <= occupancy + CNT_W'(alloc_gnt) - CNT_W'(dealloc_hit);
      if (dealloc_vld && !valid_vec[dealloc_idx])
        dealloc_err <= 1'b1;
    end
  end

`ifdef ENTRY_ALLOC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)
      stall_cnt <= '0;
    else if (alloc_req && full && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_entry_alloc8.sv
// Self-checking bench for entry_alloc8: directed table, corner sequences and
// randomized traffic against a slot-array reference model.
module tb_entry_alloc8;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       rst_aL;
  logic       alloc_req, dealloc_vld, flush;
  logic [2:0] dealloc_idx;
  logic       alloc_gnt, full, empty, dealloc_err;
  logic [2:0] alloc_idx;
  logic [7:0] valid_vec;
  logic [3:0] occupancy;
`ifdef ENTRY_ALLOC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  entry_alloc8 #(.LOW_FIRST(1), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_aL      (rst_aL),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_idx   (alloc_idx),
    .dealloc_vld (dealloc_vld),
    .dealloc_idx (dealloc_idx),
    .flush       (flush),
    .valid_vec   (valid_vec),
    .full        (full),
    .empty       (empty),
    .occupancy   (occupancy),
    .dealloc_err (dealloc_err)
`ifdef ENTRY_ALLOC_STALL_CNT_EN
    ,.stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one bit per slot plus sticky error and stall count.
  bit mv[8];
  bit merr;
  int mstall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mv[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    merr = 1'b0;
    mstall = 0;
  endtask

  task automatic exp_grant(input logic req, input logic fl, output logic eg, output logic [2:0] ei);
    eg = 1'b0;
    ei = 3'd0;
    if (req && !fl)
      for (int i = 0; i < 8; i++)
        if (!eg && !mv[i]) begin
          eg = 1'b1;
          ei = 3'(i);
        end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid_vec"}, 32'(valid_vec), 32'(m_vec()));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(m_cnt()));
    chk({tag, ".full"}, 32'(full), 32'(m_cnt() == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(m_cnt() == 0));
    chk({tag, ".dealloc_err"}, 32'(dealloc_err), 32'(merr));
`ifdef ENTRY_ALLOC_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mstall));
`endif
  endtask

  // One clock cycle: drive at negedge, check grant mid-cycle, update model at
  // posedge and check the registered state just after it.
  task automatic drive(input logic req, input logic dv, input logic [2:0] di, input logic fl,
                       output logic g, output logic [2:0] ix);
    logic eg, mfull;
    logic [2:0] ei;
    @(negedge clk);
    alloc_req = req; dealloc_vld = dv; dealloc_idx = di; flush = fl;
    #1;
    exp_grant(req, fl, eg, ei);
    chk("alloc_gnt", 32'(alloc_gnt), 32'(eg));
    chk("alloc_idx", 32'(alloc_idx), 32'(ei));
    g = alloc_gnt;
    ix = alloc_idx;
    mfull = (m_cnt() == 8);
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    end else begin
      if (dv && !mv[di]) merr = 1'b1;
      if (eg) mv[ei] = 1'b1;
      if (dv) mv[di] = 1'b0;
    end
    if (req && mfull && mstall != 65535) mstall++;
    #1;
    check_state("cycle");
  endtask

  typedef struct {
    logic req, dv;
    logic [2:0] di;
    logic fl;
    logic gnt;
    logic [2:0] idx;
    logic [7:0] vld;
    logic [3:0] occ;
    logic err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic req, input logic dv, input logic [2:0] di, input logic fl,
                     input logic gnt, input logic [2:0] idx, input logic [7:0] vld,
                     input logic [3:0] occ, input logic err);
    vec_t v;
    v = '{req, dv, di, fl, gnt, idx, vld, occ, err};
    tbl.push_back(v);
  endtask

  initial begin
    logic g;
    logic [2:0] ix;
    logic eg;
    logic [2:0] ei;
    logic rr, rd, rf;
    logic [2:0] ri;

    rst_aL = 1'b0; alloc_req = 1'b1; dealloc_vld = 1'b0; dealloc_idx = 3'd0; flush = 1'b0;
    m_reset();
    #12;
    check_state("reset");
    chk("reset.alloc_gnt", 32'(alloc_gnt), 32'd0);
    @(negedge clk);
    rst_aL = 1'b1; alloc_req = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, 1, 3'(i), 8'((9'h1 << (i + 1)) - 9'h1), 4'(i + 1), 0);
    add(1, 0, 0, 0, 0, 0, 8'hFF, 8, 0);  // full: held off
    add(1, 1, 5, 0, 0, 0, 8'hDF, 7, 0);  // freed slot not grantable yet
    add(1, 0, 0, 0, 1, 5, 8'hFF, 8, 0);
    add(1, 1, 0, 1, 0, 0, 8'h00, 0, 0);  // flush wins
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 0, 1, 3'(i), 8'((9'h1 << (i + 1)) - 9'h1), 4'(i + 1), 0);
    add(1, 1, 1, 0, 1, 4, 8'h1D, 4, 0);  // simultaneous alloc/dealloc
    add(0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 1, 0, 8'h01, 1, 0);
    add(1, 0, 0, 0, 1, 1, 8'h03, 2, 0);
    add(0, 1, 6, 0, 0, 0, 8'h03, 2, 1);  // dealloc of invalid slot
    add(0, 0, 0, 1, 0, 0, 8'h00, 0, 1);  // error survives flush
    add(0, 1, 2, 0, 0, 0, 8'h00, 0, 1);

    foreach (tbl[k]) begin
      drive(tbl[k].req, tbl[k].dv, tbl[k].di, tbl[k].fl, g, ix);
      chk($sformatf("tbl%0d.gnt", k), 32'(g), 32'(tbl[k].gnt));
      chk($sformatf("tbl%0d.idx", k), 32'(ix), 32'(tbl[k].idx));
      chk($sformatf("tbl%0d.valid_vec", k), 32'(valid_vec), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d.occupancy", k), 32'(occupancy), 32'(tbl[k].occ));
      chk($sformatf("tbl%0d.dealloc_err", k), 32'(dealloc_err), 32'(tbl[k].err));
    end

    // Fresh reset, fill, stall three cycles, then drain to 0xA5
    @(negedge clk);
    rst_aL = 1'b0; alloc_req = 1'b0; dealloc_vld = 1'b0; flush = 1'b0;
    m_reset();
    #1;
    check_state("reset2");
    @(negedge clk);
    rst_aL = 1'b1;
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, g, ix);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, g, ix);
`ifdef ENTRY_ALLOC_STALL_CNT_EN
    chk("stall.count3", 32'(stall_cnt), 32'd3);
`endif
    drive(0, 1, 1, 0, g, ix);
    drive(0, 1, 3, 0, g, ix);
    drive(0, 1, 4, 0, g, ix);
    drive(0, 1, 6, 0, g, ix);
    chk("pre_rst.valid_vec", 32'(valid_vec), 32'hA5);

    // Asynchronous reset between edges with a grant outstanding
    #1;
    alloc_req = 1'b1; dealloc_vld = 1'b0; flush = 1'b0;
    #1;
    chk("pre_rst.alloc_gnt", 32'(alloc_gnt), 32'd1);
    chk("pre_rst.alloc_idx", 32'(alloc_idx), 32'd1);
    rst_aL = 1'b0;
    m_reset();
    #1;
    check_state("async_rst");
    chk("async_rst.alloc_gnt", 32'(alloc_gnt), 32'd0);
    @(negedge clk);
    rst_aL = 1'b1; alloc_req = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rr = 1'($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      ri = 3'($urandom_range(0, 7));
      rf = 1'($urandom_range(0, 31) == 0);
      exp_grant(rr, rf, eg, ei);
      if (eg && rd && ri == ei) ri = ei + 3'd1;
      if (eg && rd && ri == ei) rd = 1'b0;
      drive(rr, rd, ri, rf, g, ix);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/entry_alloc8.md
Name: entry_alloc8

Overview:
- 8-slot valid-vector allocator for the OOO core's small queues (issue-queue and LSQ slot management).
- Tracks per-slot valid bits, grants one free slot per cycle, and frees slots on deallocation or flush.
- Drives its registered valid vector into the downstream 8-input AND reduction (and8) to form the full flag, and into a NOR reduction to form the empty flag.

Parameters:
- LOW_FIRST, 1, 1 = grant the lowest-index free slot; 0 = grant the highest-index free slot.
- CNT_W, 4, width of the occupancy count (must hold 0..8).

Ports:
- clk  in  1  core clock, rising edge.
- rst_aL  in  1  asynchronous active-low reset.
- alloc_req  in  1  requester wants one slot this cycle.
- alloc_gnt  out  1  slot granted this cycle (combinational).
- alloc_idx  out  3  index of the granted slot, valid when alloc_gnt=1.
- dealloc_vld  in  1  free one slot this cycle.
- dealloc_idx  in  3  slot to free.
- flush  in  1  synchronous clear of all slots.
- valid_vec  out  8  registered per-slot valid bits.
- full  out  1  and8(valid_vec).
- empty  out  1  no slot valid.
- occupancy  out  CNT_W  number of valid slots (registered).
- dealloc_err  out  1  registered, sticky: a dealloc targeted an invalid slot.

Behaviour:
- Reset (rst_aL=0, async):
  - valid_vec=0, occupancy=0, dealloc_err=0.
  - Consequently full=0, empty=1, alloc_gnt=0.
- Grant (combinational, same cycle):
  - free_vec = ~valid_vec, using registered state only; a slot freed this cycle is not re-grantable until the next cycle.
  - alloc_gnt = alloc_req & |free_vec & ~flush.
  - alloc_idx = priority-encoded free slot chosen per LOW_FIRST. alloc_idx=0 when no grant.
- Update (rising clk edge):
  - flush=1 → valid_vec=0, occupancy=0; alloc and dealloc in that cycle are ignored. dealloc_err is unchanged.
  - Otherwise:
    - alloc_gnt sets valid_vec[alloc_idx].
    - dealloc_vld clears valid_vec[dealloc_idx].
    - occupancy += alloc_gnt − (dealloc_vld & valid_vec[dealloc_idx]).
- Latency:
  - A granted slot appears in valid_vec, full and occupancy one cycle after the grant.
  - A freed slot becomes grantable the cycle after dealloc.
- Simultaneous alloc and dealloc:
  - Allowed, different slots by construction, since the granted slot is currently free.
  - Occupancy is unchanged.
- Full:
  - alloc_req is held off with alloc_gnt=0. No state change, no error.
  - A dealloc in the same cycle still frees its slot.
- Dealloc of an already-invalid slot:
  - valid_vec and occupancy are unchanged.
  - dealloc_err is set and stays 1 until reset.
- full and empty:
  - Pure functions of registered valid_vec; glitch-free relative to clk.
  - Invariant: occupancy == popcount(valid_vec) every cycle.
- Reset mid-operation:
  - Immediate clear regardless of clk.
  - An outstanding grant is lost; the requester must observe alloc_gnt=0.

Optional Feature:
- Macro: ENTRY_ALLOC_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0], a saturating counter incremented each cycle alloc_req=1 & full=1.
  - Reset to 0 by rst_aL; not cleared by flush.
- Undefined:
  - No port and no logic; interface otherwise identical.

Decomposition:
- Shared package core_pkg:
  - ALLOC_ENTRIES=8, ALLOC_IDX_W=3.
  - Typedef alloc_idx_t (logic [2:0]).
  - Typedef alloc_vec_t (logic [7:0]).
- One sub-module: prio_enc8.
  - 8-bit free vector in; 3-bit index plus found flag out.
  - Direction parameter passed through from LOW_FIRST.
- Full flag comes from an instantiated and8; no new reduction logic for it.

Test Plan:
- Reset then 8 back-to-back alloc_req, LOW_FIRST=1:
  - alloc_idx = 0,1,…,7.
  - full=1 on the cycle after the 8th grant; occupancy=8.
  - 9th req gives alloc_gnt=0.
- From full, dealloc_idx=5 with alloc_req=1 the same cycle:
  - Same cycle: gnt=0.
  - Next cycle: gnt=1 with idx=5; occupancy 7 then 8.
- Valid=0x0F with simultaneous alloc (gets idx 4) and dealloc idx 1:
  - Next valid_vec=0x1D; occupancy stays 4.
- Dealloc idx 6 while valid=0x03:
  - valid_vec unchanged.
  - dealloc_err=1 next cycle and stays 1 after a flush.
- flush with valid=0xFF plus concurrent alloc_req/dealloc:
  - Same cycle: alloc_gnt=0.
  - Next cycle: valid_vec=0, empty=1, occupancy=0.
- Assert rst_aL low between clk edges while valid=0xA5:
  - Outputs clear immediately without waiting for clk.
  - With ENTRY_ALLOC_STALL_CNT_EN: stall_cnt returns to 0 after having counted 3 full-stall cycles beforehand.
